// File: rtl/instamp_range_seq.sv
// rtl/instamp_range_seq.sv - instrumentation-amp channel/gain sequencer with break-before-make, settle and auto-range
// Outputs are registered decodes of the sequencer state, so they trail the state register by one cycle.
module instamp_range_seq #(
   parameter int N_GAIN        = 4,
   parameter int N_CH          = 4,
   parameter int BBM_CYCLES    = 4,
   parameter int SETTLE_CYCLES = 64,
   parameter int CNT_W         = 8,
   parameter int GAIN_W        = (N_GAIN > 1) ? $clog2(N_GAIN) : 1,
   parameter int CH_W          = (N_CH > 1) ? $clog2(N_CH) : 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ena,
   input  logic              start,
   input  logic              auto_range,
   input  logic [GAIN_W-1:0] gain_req,
   input  logic [CH_W-1:0]   ch_req,
   input  logic              comp_hi,
   input  logic              comp_lo,
   output logic [N_CH-1:0]   ch_sw,
   output logic [N_GAIN-1:0] gain_sw,
   output logic [GAIN_W-1:0] gain_idx,
   output logic              sample,
   output logic              busy,
   output logic              range_err
);

   typedef enum logic [2:0] {S_IDLE, S_BREAK, S_SETTLE, S_CHECK, S_SAMPLE} state_t;
   typedef enum logic [1:0] {L_NONE, L_UP, L_DOWN} lock_t;

   localparam logic [CNT_W-1:0]  BBM_LAST    = CNT_W'(BBM_CYCLES - 1);
   localparam logic [CNT_W-1:0]  SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
   localparam logic [GAIN_W-1:0] GAIN_MAX    = GAIN_W'(N_GAIN - 1);
   localparam logic [CH_W-1:0]   CH_MAX      = CH_W'(N_CH - 1);

   state_t              r_state, w_state_nxt;
   lock_t               r_lock, w_lock_nxt;
   logic [CNT_W-1:0]    r_timer, w_timer_nxt;
   logic [CH_W-1:0]     r_ch, w_ch_nxt;
   logic [GAIN_W-1:0]   r_gain_idx, w_gain_nxt;
   logic                r_auto, w_auto_nxt;
   logic                r_range_err, w_err_nxt;
   logic                r_hi_s1, r_hi_s2, r_lo_s1, r_lo_s2;
   logic [N_CH-1:0]     r_ch_sw, w_ch_sw_nxt;
   logic [N_GAIN-1:0]   r_gain_sw, w_gain_sw_nxt;
   logic                r_sample, w_sample_nxt;
   logic                r_busy, w_busy_nxt;

   logic [CH_W-1:0]     w_ch_clamp;
   logic [GAIN_W-1:0]   w_gain_clamp;
   logic [N_CH-1:0]     w_ch_dec;
   logic [N_GAIN-1:0]   w_gain_dec;

   assign w_ch_clamp   = ({1'b0, ch_req} >= (CH_W+1)'(N_CH)) ? CH_MAX : ch_req;
   assign w_gain_clamp = ({1'b0, gain_req} >= (GAIN_W+1)'(N_GAIN)) ? GAIN_MAX : gain_req;
   assign w_ch_dec     = N_CH'(1) << r_ch;
   assign w_gain_dec   = N_GAIN'(1) << r_gain_idx;

   always_comb begin
      w_state_nxt = r_state;
      w_lock_nxt  = r_lock;
      w_timer_nxt = r_timer;
      w_ch_nxt    = r_ch;
      w_gain_nxt  = r_gain_idx;
      w_auto_nxt  = r_auto;
      w_err_nxt   = r_range_err;
      if (!ena) begin
         w_state_nxt = S_IDLE;
         w_timer_nxt = '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  w_ch_nxt    = w_ch_clamp;
                  w_gain_nxt  = w_gain_clamp;
                  w_auto_nxt  = auto_range;
                  w_err_nxt   = 1'b0;
                  w_lock_nxt  = L_NONE;
                  w_timer_nxt = '0;
                  w_state_nxt = S_BREAK;
               end
            end
            S_BREAK: begin
               if (r_timer == BBM_LAST) begin
                  w_timer_nxt = '0;
                  w_state_nxt = S_SETTLE;
               end else begin
                  w_timer_nxt = r_timer + CNT_W'(1);
               end
            end
            S_SETTLE: begin
               if (r_timer == SETTLE_LAST) begin
                  w_timer_nxt = '0;
                  w_state_nxt = S_CHECK;
               end else begin
                  w_timer_nxt = r_timer + CNT_W'(1);
               end
            end
            S_CHECK: begin
               w_state_nxt = S_SAMPLE;
               // The lock forbids reversing direction within one sequence, so ranging cannot oscillate.
               if (r_auto) begin
                  if (r_hi_s2 && r_lo_s2) begin
                     w_err_nxt = 1'b1;
                  end else if (r_hi_s2) begin
                     if (r_gain_idx != '0 && r_lock != L_UP) begin
                        w_gain_nxt  = r_gain_idx - GAIN_W'(1);
                        w_lock_nxt  = L_DOWN;
                        w_state_nxt = S_BREAK;
                     end else begin
                        w_err_nxt = 1'b1;
                     end
                  end else if (r_lo_s2) begin
                     if (r_gain_idx != GAIN_MAX && r_lock != L_DOWN) begin
                        w_gain_nxt  = r_gain_idx + GAIN_W'(1);
                        w_lock_nxt  = L_UP;
                        w_state_nxt = S_BREAK;
                     end else begin
                        w_err_nxt = 1'b1;
                     end
                  end
               end
            end
            S_SAMPLE: w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
         endcase
      end
   end

   always_comb begin
      w_ch_sw_nxt   = r_ch_sw;
      w_gain_sw_nxt = r_gain_sw;
      w_sample_nxt  = 1'b0;
      w_busy_nxt    = 1'b0;
      if (!ena) begin
         w_ch_sw_nxt   = '0;
         w_gain_sw_nxt = '0;
      end else begin
         case (r_state)
            S_BREAK: begin
               w_ch_sw_nxt   = '0;
               w_gain_sw_nxt = '0;
               w_busy_nxt    = 1'b1;
            end
            S_SETTLE, S_CHECK: begin
               w_ch_sw_nxt   = w_ch_dec;
               w_gain_sw_nxt = w_gain_dec;
               w_busy_nxt    = 1'b1;
            end
            S_SAMPLE: begin
               w_ch_sw_nxt   = w_ch_dec;
               w_gain_sw_nxt = w_gain_dec;
               w_sample_nxt  = 1'b1;
               w_busy_nxt    = 1'b1;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_lock      <= L_NONE;
         r_timer     <= '0;
         r_ch        <= '0;
         r_gain_idx  <= '0;
         r_auto      <= 1'b0;
         r_range_err <= 1'b0;
         r_hi_s1     <= 1'b0;
         r_hi_s2     <= 1'b0;
         r_lo_s1     <= 1'b0;
         r_lo_s2     <= 1'b0;
         r_ch_sw     <= '0;
         r_gain_sw   <= '0;
         r_sample    <= 1'b0;
         r_busy      <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_lock      <= w_lock_nxt;
         r_timer     <= w_timer_nxt;
         r_ch        <= w_ch_nxt;
         r_gain_idx  <= w_gain_nxt;
         r_auto      <= w_auto_nxt;
         r_range_err <= w_err_nxt;
         r_hi_s1     <= comp_hi;
         r_hi_s2     <= r_hi_s1;
         r_lo_s1     <= comp_lo;
         r_lo_s2     <= r_lo_s1;
         r_ch_sw     <= w_ch_sw_nxt;
         r_gain_sw   <= w_gain_sw_nxt;
         r_sample    <= w_sample_nxt;
         r_busy      <= w_busy_nxt;
      end
   end

   assign ch_sw     = r_ch_sw;
   assign gain_sw   = r_gain_sw;
   assign gain_idx  = r_gain_idx;
   assign sample    = r_sample;
   assign busy      = r_busy;
   assign range_err = r_range_err;

endmodule

// File: tb/tb_instamp_range_seq.sv
// tb/tb_instamp_range_seq.sv - randomized bench for instamp_range_seq against a timeline model
module tb_instamp_range_seq;
   localparam int N_GAIN = 4;
   localparam int N_CH   = 4;
   localparam int BBM    = 4;
   localparam int SETTLE = 64;
   localparam int PASS   = BBM + SETTLE + 1;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       ena = 1'b0;
   logic       start = 1'b0;
   logic       auto_range = 1'b0;
   logic [1:0] gain_req = 2'd0;
   logic [1:0] ch_req = 2'd0;
   logic       comp_hi = 1'b0;
   logic       comp_lo = 1'b0;
   logic [3:0] ch_sw, gain_sw;
   logic [1:0] gain_idx;
   logic       sample, busy, range_err;

   always #5 clk = ~clk;

   instamp_range_seq #(.N_GAIN(N_GAIN), .N_CH(N_CH), .BBM_CYCLES(BBM), .SETTLE_CYCLES(SETTLE), .CNT_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .ena(ena), .start(start), .auto_range(auto_range),
      .gain_req(gain_req), .ch_req(ch_req), .comp_hi(comp_hi), .comp_lo(comp_lo),
      .ch_sw(ch_sw), .gain_sw(gain_sw), .gain_idx(gain_idx), .sample(sample),
      .busy(busy), .range_err(range_err)
   );

   int vectors = 0;
   int errors  = 0;

   // Comparator scenario: bit g says whether that comparator fires while gain g is applied.
   logic [3:0] hm = 4'd0, lm = 4'd0;

   bit   m_active = 0;
   int   m_t = 0, m_n = 0, m_ch = 0;
   bit   m_err = 0;
   int   m_g [N_GAIN];
   logic [3:0] e_ch_sw = 4'd0, e_gain_sw = 4'd0;
   logic [1:0] e_gain = 2'd0;
   logic       e_sample = 1'b0, e_busy = 1'b0, e_err = 1'b0;
   logic [3:0] prev_ch = 4'd0, prev_gsw = 4'd0;

   task automatic plan(input int g0, input bit au);
      int g, lock;
      bit done;
      g = g0; lock = 0; done = !au; m_n = 0; m_err = 0; m_g[0] = g0;
      while (!done) begin
         if (!hm[g] && !lm[g]) done = 1;
         else if (hm[g] && lm[g]) begin m_err = 1; done = 1; end
         else if (hm[g]) begin
            if (g > 0 && lock != 1) begin g--; lock = 2; m_n++; m_g[m_n] = g; end
            else begin m_err = 1; done = 1; end
         end else begin
            if (g < N_GAIN - 1 && lock != 2) begin g++; lock = 1; m_n++; m_g[m_n] = g; end
            else begin m_err = 1; done = 1; end
         end
      end
   endtask

   task automatic show_on(input int ch, input int g);
      e_ch_sw   = 4'b0001 << ch;
      e_gain_sw = 4'b0001 << g;
   endtask

   task automatic model_edge();
      int idx;
      if (!rst_n) begin
         e_ch_sw = 0; e_gain_sw = 0; e_gain = 0; e_sample = 0; e_busy = 0; e_err = 0; m_active = 0;
         return;
      end
      if (!ena) begin
         e_ch_sw = 0; e_gain_sw = 0; e_sample = 0; e_busy = 0; m_active = 0;
         return;
      end
      if (m_active) begin
         m_t++;
         if (m_t < PASS * (m_n + 1) + 2) begin
            e_busy = 1;
            if (m_t == PASS * (m_n + 1) + 1) begin
               show_on(m_ch, m_g[m_n]);
               e_sample = 1;
            end else begin
               e_sample = 0;
               if ((m_t - 1) % PASS < BBM) begin e_ch_sw = 0; e_gain_sw = 0; end
               else show_on(m_ch, m_g[(m_t - 1) / PASS]);
            end
            idx = (m_t / PASS > m_n) ? m_n : m_t / PASS;
            e_gain = 2'(m_g[idx]);
            e_err  = m_err && (m_t >= PASS * (m_n + 1));
            return;
         end
         m_active = 0;
      end
      e_sample = 0; e_busy = 0;
      if (start) begin
         m_ch = int'(ch_req);
         plan(int'(gain_req), auto_range);
         m_active = 1; m_t = 0; e_gain = gain_req; e_err = 0;
      end
   endtask

   task automatic compare();
      bit bad;
      vectors++;
      bad = ({ch_sw, gain_sw, gain_idx, sample, busy, range_err} !==
             {e_ch_sw, e_gain_sw, e_gain, e_sample, e_busy, e_err});
      if (!$onehot0(ch_sw) || !$onehot0(gain_sw)) bad = 1;
      if (prev_ch != 0 && ch_sw != 0 && prev_ch != ch_sw) bad = 1;
      if (prev_gsw != 0 && gain_sw != 0 && prev_gsw != gain_sw) bad = 1;
      prev_ch = ch_sw; prev_gsw = gain_sw;
      if (bad) begin
         errors++;
         $display("FAIL cycle_check t=%0t: got ch_sw=%b gain_sw=%b gain_idx=%0d sample=%b busy=%b range_err=%b, expected ch_sw=%b gain_sw=%b gain_idx=%0d sample=%b busy=%b range_err=%b",
                  $time, ch_sw, gain_sw, gain_idx, sample, busy, range_err,
                  e_ch_sw, e_gain_sw, e_gain, e_sample, e_busy, e_err);
      end
   endtask

   task automatic chk(input string name, input int act, input int exp);
      vectors++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   initial begin
      forever begin
         @(posedge clk);
         model_edge();
         #1 compare();
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         comp_hi = hm[e_gain];
         comp_lo = lm[e_gain];
      end
   end

   task automatic run_directed(input string name, input bit au, input int ch, input int g,
                               input logic [3:0] h, input logic [3:0] l, input int exp_lat,
                               input int exp_g, input bit exp_err, input int exp_ch_sw,
                               input int exp_gsw, input bit poke);
      int cnt;
      bit seen;
      @(negedge clk);
      hm = h; lm = l; auto_range = au; ch_req = 2'(ch); gain_req = 2'(g); start = 1;
      @(posedge clk);
      #1 start = 0;
      cnt = 0; seen = 0;
      while (cnt < 1000 && !seen) begin
         @(posedge clk);
         #1 cnt++;
         if (poke && cnt == 30) start = 1;
         if (poke && cnt == 31) start = 0;
         if (cnt == BBM) chk({name, "_bbm_open"}, int'({ch_sw, gain_sw}), 0);
         if (cnt == BBM + 1) begin
            chk({name, "_ch_sw"}, int'(ch_sw), exp_ch_sw);
            chk({name, "_gain_sw"}, int'(gain_sw), exp_gsw);
         end
         if (sample) seen = 1;
      end
      chk({name, "_latency"}, cnt, exp_lat);
      chk({name, "_gain_idx"}, int'(gain_idx), exp_g);
      chk({name, "_range_err"}, int'(range_err), int'(exp_err));
      @(posedge clk);
      #1 chk({name, "_busy_low"}, int'({busy, sample}), 0);
   endtask

   initial begin
      int wait_cnt;
      repeat (3) @(posedge clk);
      #1 chk("reset_outputs", int'({ch_sw, gain_sw, gain_idx, sample, busy, range_err}), 0);
      @(negedge clk);
      rst_n = 1; ena = 1;

      run_directed("manual",      0, 2, 1, 4'b1111, 4'b0000, 70,  1, 0, 4'b0100, 4'b0010, 0);
      run_directed("auto_down",   1, 1, 3, 4'b1100, 4'b0000, 208, 1, 0, 4'b0010, 4'b1000, 1);
      run_directed("sat_low",     1, 0, 0, 4'b1111, 4'b0000, 70,  0, 1, 4'b0001, 4'b0001, 0);
      run_directed("sat_high",    1, 3, 3, 4'b0000, 4'b1111, 70,  3, 1, 4'b1000, 4'b1000, 0);
      run_directed("anti_osc",    1, 0, 2, 4'b0100, 4'b0010, 139, 1, 1, 4'b0001, 4'b0100, 0);
      run_directed("both_comps",  1, 2, 1, 4'b0010, 4'b0010, 70,  1, 1, 4'b0100, 4'b0010, 0);

      @(negedge clk);
      hm = 0; lm = 0; auto_range = 0; ch_req = 1; gain_req = 2; start = 1;
      @(posedge clk);
      #1 start = 0;
      repeat (20) @(posedge clk);
      #1 ena = 0;
      @(posedge clk);
      #1 chk("abort_switches", int'({ch_sw, gain_sw}), 0);
      chk("abort_busy_sample", int'({busy, sample}), 0);
      chk("abort_gain_hold", int'(gain_idx), 2);
      ena = 1;
      repeat (3) @(posedge clk);
      #1 chk("abort_stays_open", int'({ch_sw, gain_sw, busy}), 0);

      @(negedge clk);
      ch_req = 3; gain_req = 3; start = 1;
      @(posedge clk);
      #1 start = 0;
      @(posedge clk);
      #1 chk("break_busy", int'(busy), 1);
      #2 rst_n = 0;
      #1 chk("async_reset_outputs", int'({ch_sw, gain_sw, gain_idx, sample, busy, range_err}), 0);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1;

      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         hm = 4'($urandom); lm = 4'($urandom);
         auto_range = 1'($urandom); ch_req = 2'($urandom); gain_req = 2'($urandom);
         ena = 1; start = 1;
         @(negedge clk);
         start = 0;
         wait_cnt = 0;
         while (m_active && wait_cnt < 1000) begin
            @(negedge clk);
            wait_cnt++;
            start = ($urandom_range(0, 99) == 0);
            ena   = ($urandom_range(0, 499) != 0);
         end
         start = 0; ena = 1;
         if (wait_cnt >= 1000) begin
            vectors++; errors++;
            $display("FAIL random_timeout: got still busy after %0d cycles expected idle", wait_cnt);
         end
      end
      repeat (3) @(posedge clk);
      #2 $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule
